// File: rtl/demux_32_bit_1x2_buf_if.sv
// -----------------------------------------------------------------------------
// demux_32_bit_1x2_buf_if
// Bundles the data-path and handshake signals of demux_32_bit_1x2_buf.
//   in_data/in_valid/control/in_ready   : upstream word offer and destination
//   out_dataN/out_validN/out_readyN     : per-channel buffered head word
//   xfer_cntN                           : accepted-word counters per channel
// The master modport is the traffic side (source and sinks). The slave
// modport is the demux itself.
// -----------------------------------------------------------------------------
interface demux_32_bit_1x2_buf_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        control;
   logic        in_ready;
   logic [31:0] out_data1;
   logic [31:0] out_data2;
   logic        out_valid1;
   logic        out_valid2;
   logic        out_ready1;
   logic        out_ready2;
   logic [15:0] xfer_cnt1;
   logic [15:0] xfer_cnt2;

   modport master (
      output in_data, in_valid, control, out_ready1, out_ready2,
      input  in_ready, out_data1, out_data2, out_valid1, out_valid2,
             xfer_cnt1, xfer_cnt2
   );

   modport slave (
      input  in_data, in_valid, control, out_ready1, out_ready2,
      output in_ready, out_data1, out_data2, out_valid1, out_valid2,
             xfer_cnt1, xfer_cnt2
   );
endinterface

// File: rtl/demux_32_bit_1x2_buf.sv
// -----------------------------------------------------------------------------
// demux_32_bit_1x2_buf
// Routes 32-bit words to one of two output channels. Each channel has its
// own 2-entry FIFO.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : demux_32_bit_1x2_buf_if.slave. It holds the input offer, both
//          channel outputs and the per-channel accept counters.
// control=0 selects channel 1 (index 0). control=1 selects channel 2 (index 1).
// -----------------------------------------------------------------------------
module demux_32_bit_1x2_buf (
   input logic                    clk,
   input logic                    rst,
   demux_32_bit_1x2_buf_if.slave  bus
);

   localparam int NCH = 2;

   logic [31:0]    mem_q [NCH][2];
   logic [NCH-1:0] wr_ptr_q, wr_ptr_d;
   logic [NCH-1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0]     occ_q [NCH];
   logic [1:0]     occ_d [NCH];
   logic [15:0]    cnt_q [NCH];
   logic [15:0]    cnt_d [NCH];

   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;
   logic [NCH-1:0] out_ready_w;
   logic           in_ready_w;

   // Readiness looks only at the registered occupancy of the selected
   // channel. A full channel cannot take a word even when it pops in the
   // same cycle. This keeps the out_ready inputs off the in_ready path.
   assign in_ready_w  = (occ_q[bus.control] != 2'd2);
   assign out_ready_w = {bus.out_ready2, bus.out_ready1};

   // NOTE: every signal written here gets a value first. This prevents any
   // path from leaving one unassigned, which would infer a latch.
   always_comb begin
      push     = '0;
      pop      = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      cnt_d    = cnt_q;
      for (int c = 0; c < NCH; c++) begin
         push[c]     = bus.in_valid && in_ready_w && (int'(bus.control) == c);
         pop[c]      = (occ_q[c] != 2'd0) && out_ready_w[c];
         // 1-bit pointers wrap by toggling.
         wr_ptr_d[c] = wr_ptr_q[c] ^ push[c];
         rd_ptr_d[c] = rd_ptr_q[c] ^ pop[c];
         case ({push[c], pop[c]})
            2'b10:   occ_d[c] = occ_q[c] + 2'd1;
            2'b01:   occ_d[c] = occ_q[c] - 2'd1;
            default: occ_d[c] = occ_q[c];
         endcase
         cnt_d[c]    = cnt_q[c] + 16'(push[c]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments. All registers
   // then update together from values sampled before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int c = 0; c < NCH; c++) begin
            occ_q[c] <= 2'd0;
            cnt_q[c] <= 16'd0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage has no reset. Its contents matter only while occupancy
   // is non-zero, and occupancy is cleared by reset. A write during reset
   // is harmless for the same reason.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (push[c]) mem_q[c][wr_ptr_q[c]] <= bus.in_data;
      end
   end

   assign bus.in_ready   = in_ready_w;
   assign bus.out_data1  = mem_q[0][rd_ptr_q[0]];
   assign bus.out_data2  = mem_q[1][rd_ptr_q[1]];
   assign bus.out_valid1 = (occ_q[0] != 2'd0);
   assign bus.out_valid2 = (occ_q[1] != 2'd0);
   assign bus.xfer_cnt1  = cnt_q[0];
   assign bus.xfer_cnt2  = cnt_q[1];

endmodule

// File: tb/tb_demux_32_bit_1x2_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_32_bit_1x2_buf
// Directed bench for demux_32_bit_1x2_buf. Inputs change 1 time unit after
// the rising edge. Outputs are sampled 1 time unit later, well clear of the
// edge.
// -----------------------------------------------------------------------------
module tb_demux_32_bit_1x2_buf;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   demux_32_bit_1x2_buf_if bus ();

   demux_32_bit_1x2_buf dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      rst            = 1'b1;
      bus.in_data    = '0;
      bus.in_valid   = 1'b0;
      bus.control    = 1'b0;
      bus.out_ready1 = 1'b0;
      bus.out_ready2 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      settle();

      // Reset state
      check("rst_valid1", 32'(bus.out_valid1), 32'd0);
      check("rst_valid2", 32'(bus.out_valid2), 32'd0);
      check("rst_cnt1",   32'(bus.xfer_cnt1),  32'd0);
      check("rst_cnt2",   32'(bus.xfer_cnt2),  32'd0);
      check("rst_ready_c0", 32'(bus.in_ready), 32'd1);
      bus.control = 1'b1;
      settle();
      check("rst_ready_c1", 32'(bus.in_ready), 32'd1);

      // Reset then route
      tick();
      bus.control  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA5A5_0001;
      tick();
      bus.in_valid = 1'b0;
      settle();
      check("route_valid1", 32'(bus.out_valid1), 32'd1);
      check("route_data1",  bus.out_data1,       32'hA5A5_0001);
      check("route_valid2", 32'(bus.out_valid2), 32'd0);
      check("route_cnt1",   32'(bus.xfer_cnt1),  32'd1);
      bus.out_ready1 = 1'b1;
      tick();
      bus.out_ready1 = 1'b0;
      settle();
      check("route_drain", 32'(bus.out_valid1), 32'd0);

      // Fill and stall on channel 2
      bus.control  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hB000_0000;
      settle();
      check("fill_rdy0", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_data = 32'hB000_0001;
      settle();
      check("fill_rdy1", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_data = 32'hB000_0002;
      settle();
      check("fill_rdy2_full", 32'(bus.in_ready), 32'd0);
      check("fill_head2",     bus.out_data2,     32'hB000_0000);
      tick();
      check("fill_cnt2", 32'(bus.xfer_cnt2), 32'd2);
      bus.control = 1'b0;
      settle();
      check("fill_rdy_other", 32'(bus.in_ready), 32'd1);
      bus.in_valid   = 1'b0;
      bus.out_ready2 = 1'b1;
      settle();
      check("fill_pop0", bus.out_data2, 32'hB000_0000);
      tick();
      check("fill_pop1", bus.out_data2, 32'hB000_0001);
      tick();
      check("fill_empty2", 32'(bus.out_valid2), 32'd0);
      bus.out_ready2 = 1'b0;

      // Full channel 1 with a concurrent pop
      bus.control  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hC000_0000;
      tick();
      bus.in_data  = 32'hC000_0001;
      tick();
      bus.in_data    = 32'hC000_0002;
      bus.out_ready1 = 1'b1;
      settle();
      check("fullpop_rdy", 32'(bus.in_ready), 32'd0);
      tick();
      bus.out_ready1 = 1'b0;
      settle();
      check("fullpop_head", bus.out_data1,      32'hC000_0001);
      check("fullpop_cnt",  32'(bus.xfer_cnt1), 32'd3);
      check("fullpop_rdy2", 32'(bus.in_ready),  32'd1);
      tick();
      bus.in_valid = 1'b0;
      settle();
      check("fullpop_cnt2", 32'(bus.xfer_cnt1), 32'd4);
      check("fullpop_ord0", bus.out_data1,      32'hC000_0001);
      bus.out_ready1 = 1'b1;
      tick();
      check("fullpop_ord1", bus.out_data1, 32'hC000_0002);
      tick();
      check("fullpop_empty", 32'(bus.out_valid1), 32'd0);

      // Streaming 8 words through channel 1
      bus.control = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'hD000_0000 + 32'(i);
         settle();
         check($sformatf("stream_rdy%0d", i), 32'(bus.in_ready), 32'd1);
         tick();
         check($sformatf("stream_dat%0d", i), bus.out_data1, 32'hD000_0000 + 32'(i));
      end
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready1 = 1'b0;
      check("stream_empty", 32'(bus.out_valid1), 32'd0);
      check("stream_cnt1",  32'(bus.xfer_cnt1),  32'd12);

      // Counter wrap on channel 2 (count currently 2)
      bus.control    = 1'b1;
      bus.out_ready2 = 1'b1;
      bus.in_valid   = 1'b1;
      for (int i = 0; i < 65533; i++) begin
         bus.in_data = 32'(i);
         tick();
      end
      check("wrap_ffff", 32'(bus.xfer_cnt2), 32'h0000_FFFF);
      tick();
      check("wrap_zero", 32'(bus.xfer_cnt2), 32'd0);
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready2 = 1'b0;
      check("wrap_empty", 32'(bus.out_valid2), 32'd0);

      // Reset beats an accept in the same cycle
      bus.control  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hEEEE_0000;
      rst          = 1'b1;
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      settle();
      check("rstprio_valid1", 32'(bus.out_valid1), 32'd0);
      check("rstprio_cnt1",   32'(bus.xfer_cnt1),  32'd0);

      // Mid-operation reset with both channels full
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.control = (i >= 2);
         bus.in_data = 32'hF000_0000 + 32'(i);
         tick();
      end
      check("mid_full1", 32'(bus.out_valid1), 32'd1);
      check("mid_full2", 32'(bus.out_valid2), 32'd1);
      bus.control    = 1'b0;
      bus.out_ready1 = 1'b1;
      rst            = 1'b1;
      tick();
      rst            = 1'b0;
      bus.in_valid   = 1'b0;
      bus.out_ready1 = 1'b0;
      settle();
      check("mid_valid1", 32'(bus.out_valid1), 32'd0);
      check("mid_valid2", 32'(bus.out_valid2), 32'd0);
      check("mid_cnt1",   32'(bus.xfer_cnt1),  32'd0);
      check("mid_cnt2",   32'(bus.xfer_cnt2),  32'd0);
      check("mid_rdy_c0", 32'(bus.in_ready),   32'd1);
      bus.control = 1'b1;
      settle();
      check("mid_rdy_c1", 32'(bus.in_ready),   32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
